// File: rtl/pad_in_conditioner.sv
// Conditions pad-side async inputs: core reset stretch/release, fetch enable sync and gating,
// UART line synchronisers. Optional fetch enable debounce filter under DEBOUNCE_FETCH_EN.
module pad_in_conditioner #(
  parameter int unsigned             SYNC_STAGES     = 2,
  parameter int unsigned             RST_HOLD_CYCLES = 16,
  parameter int unsigned             DEBOUNCE_CYCLES = 8,
  parameter int unsigned             N_ASYNC         = 3,
  parameter logic [N_ASYNC-1:0]      ASYNC_RST_VAL   = {N_ASYNC{1'b1}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_enable_pad_i,
  input  logic [N_ASYNC-1:0] async_pad_i,
  output logic               core_rst_n_o,
  output logic               fetch_enable_o,
  output logic [N_ASYNC-1:0] async_sync_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StIdle = 2'd1,
    StRun  = 2'd2
  } state_e;

  localparam logic [7:0] HoldLast = 8'(RST_HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] rst_sync_d, rst_sync_q;
  logic [SYNC_STAGES-1:0] fe_sync_d, fe_sync_q;
  logic [N_ASYNC-1:0]     async_sync_d [SYNC_STAGES];
  logic [N_ASYNC-1:0]     async_sync_q [SYNC_STAGES];
  logic [7:0]             hold_cnt_d, hold_cnt_q;
  state_e                 state_d, state_q;
  logic                   core_rst_n_d, core_rst_n_q;
  logic                   fetch_enable_d, fetch_enable_q;
  logic                   rst_rel;
  logic                   fe_s;
  logic                   fe_f;

  assign rst_rel = rst_sync_q[SYNC_STAGES-1];
  assign fe_s    = fe_sync_q[SYNC_STAGES-1];

  always_comb begin
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    fe_sync_d  = {fe_sync_q[SYNC_STAGES-2:0], fetch_enable_pad_i};
    async_sync_d[0] = async_pad_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      async_sync_d[i] = async_sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
      fe_sync_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        async_sync_q[i] <= ASYNC_RST_VAL;
      end
    end else begin
      rst_sync_q <= rst_sync_d;
      fe_sync_q  <= fe_sync_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        async_sync_q[i] <= async_sync_d[i];
      end
    end
  end

`ifdef DEBOUNCE_FETCH_EN
  logic [7:0] deb_cnt_d, deb_cnt_q;
  logic       fe_f_d, fe_f_q;

  // Any agreement between fe_s and fe_f restarts the stability window.
  always_comb begin
    deb_cnt_d = '0;
    fe_f_d    = fe_f_q;
    if (fe_s != fe_f_q) begin
      if (deb_cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
        fe_f_d = fe_s;
      end else begin
        deb_cnt_d = deb_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      fe_f_q    <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      fe_f_q    <= fe_f_d;
    end
  end

  assign fe_f = fe_f_q;
`else
  assign fe_f = fe_s;
`endif

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == StHold && rst_rel) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StHold: if (rst_rel && hold_cnt_q == HoldLast) state_d = StIdle;
      StIdle: if (fe_f) state_d = StRun;
      StRun:  if (!fe_f) state_d = StIdle;
      default: state_d = StHold;
    endcase
    // Outputs are registered copies of the next state so they switch on the transition edge.
    core_rst_n_d   = (state_d != StHold);
    fetch_enable_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q     <= '0;
      state_q        <= StHold;
      core_rst_n_q   <= 1'b0;
      fetch_enable_q <= 1'b0;
    end else begin
      hold_cnt_q     <= hold_cnt_d;
      state_q        <= state_d;
      core_rst_n_q   <= core_rst_n_d;
      fetch_enable_q <= fetch_enable_d;
    end
  end

  assign core_rst_n_o   = core_rst_n_q;
  assign fetch_enable_o = fetch_enable_q;
  assign async_sync_o   = async_sync_q[SYNC_STAGES-1];
  assign state_o        = state_q;

endmodule

// File: tb/tb_pad_in_conditioner.sv
// Testbench for pad_in_conditioner: directed scenarios plus randomized run against a
// behavioural model built from delay lines and stability-run counting.
module tb_pad_in_conditioner;

  localparam int S   = 2;
  localparam int H   = 16;
  localparam int D   = 8;
  localparam int REL = S + H;
`ifdef DEBOUNCE_FETCH_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  localparam int FALL_LAT = DEB ? S + D : S;

  logic       clk;
  logic       rst_n;
  logic       fetch_pad;
  logic [2:0] async_pad;
  logic       core_rst_n_o;
  logic       fetch_enable_o;
  logic [2:0] async_sync_o;
  logic [1:0] state_o;

  int tests_run;
  int tests_failed;

  // Reference model state
  int         edges;
  logic       core_m;
  logic       fe_m;
  logic       fe_f_m;
  int         run_m;
  logic       fe_hist[$];
  logic [2:0] as_hist[$];

  pad_in_conditioner dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fetch_enable_pad_i(fetch_pad),
    .async_pad_i       (async_pad),
    .core_rst_n_o      (core_rst_n_o),
    .fetch_enable_o    (fetch_enable_o),
    .async_sync_o      (async_sync_o),
    .state_o           (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    edges  = 0;
    core_m = 1'b0;
    fe_m   = 1'b0;
    fe_f_m = 1'b0;
    run_m  = 0;
    fe_hist = {};
    as_hist = {};
    for (int i = 0; i < S; i++) begin
      fe_hist.push_back(1'b0);
      as_hist.push_back(3'b111);
    end
  endtask

  task automatic model_step();
    logic fe_s_prev;
    logic fe_f_eff;
    fe_s_prev = fe_hist[S-1];
    fe_f_eff  = DEB ? fe_f_m : fe_s_prev;
    fe_m      = core_m & fe_f_eff;
    if (fe_s_prev == fe_f_m) begin
      run_m = 0;
    end else begin
      run_m++;
      if (run_m == D) begin
        fe_f_m = fe_s_prev;
        run_m  = 0;
      end
    end
    if (edges < REL) edges++;
    core_m = (edges >= REL);
    fe_hist.push_front(fetch_pad);
    void'(fe_hist.pop_back());
    as_hist.push_front(async_pad);
    void'(as_hist.pop_back());
  endtask

  // Advance across one rising edge; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    fetch_pad = 1'b0;
    async_pad = 3'b111;
    repeat (5) tick();
    tests_run++;
    if (core_rst_n_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_core_rst got %b exp 0", core_rst_n_o);
    end
    tests_run++;
    if (fetch_enable_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fetch got %b exp 0", fetch_enable_o);
    end
    tests_run++;
    if (state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state got %0d exp 0", state_o);
    end
    tests_run++;
    if (async_sync_o !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_async got %b exp 111", async_sync_o);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= REL + 1; e++) begin
      logic [1:0] exp_st;
      tick();
      exp_st = (e >= REL) ? 2'd1 : 2'd0;
      tests_run++;
      if (core_rst_n_o !== (e >= REL)) begin
        tests_failed++;
        $display("FAIL powerup_core_rst edge %0d got %b exp %b", e, core_rst_n_o, e >= REL);
      end
      tests_run++;
      if (fetch_enable_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL powerup_fetch edge %0d got %b exp 0", e, fetch_enable_o);
      end
      tests_run++;
      if (state_o !== exp_st) begin
        tests_failed++;
        $display("FAIL powerup_state edge %0d got %0d exp %0d", e, state_o, exp_st);
      end
    end
  endtask

  task automatic test_fetch_high();
    rst_n = 1'b0;
    model_reset();
    fetch_pad = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int e = 1; e <= REL + 1; e++) begin
      logic [1:0] exp_st;
      tick();
      exp_st = (e >= REL + 1) ? 2'd2 : ((e >= REL) ? 2'd1 : 2'd0);
      tests_run++;
      if (core_rst_n_o !== (e >= REL)) begin
        tests_failed++;
        $display("FAIL fetchhigh_core_rst edge %0d got %b exp %b", e, core_rst_n_o, e >= REL);
      end
      tests_run++;
      if (fetch_enable_o !== (e >= REL + 1)) begin
        tests_failed++;
        $display("FAIL fetchhigh_fetch edge %0d got %b exp %b", e, fetch_enable_o,
                 e >= REL + 1);
      end
      tests_run++;
      if (state_o !== exp_st) begin
        tests_failed++;
        $display("FAIL fetchhigh_state edge %0d got %0d exp %0d", e, state_o, exp_st);
      end
    end
  endtask

  task automatic test_debounce();
    // Short low pulse: 5 samples low
    fetch_pad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      logic exp_fe;
      tick();
      if (i == 4) fetch_pad = 1'b1;
      exp_fe = DEB ? 1'b1 : !(i >= S && i < S + 5);
      tests_run++;
      if (fetch_enable_o !== exp_fe) begin
        tests_failed++;
        $display("FAIL short_pulse_fetch i=%0d got %b exp %b", i, fetch_enable_o, exp_fe);
      end
    end
    // Long low: 12 samples low, then high again
    fetch_pad = 1'b0;
    for (int i = 0; i < 12 + FALL_LAT + 3; i++) begin
      logic       exp_fe;
      logic [1:0] exp_st;
      tick();
      if (i == 11) fetch_pad = 1'b1;
      exp_fe = !(i >= FALL_LAT && i < 12 + FALL_LAT);
      exp_st = exp_fe ? 2'd2 : 2'd1;
      tests_run++;
      if (fetch_enable_o !== exp_fe) begin
        tests_failed++;
        $display("FAIL long_low_fetch i=%0d got %b exp %b", i, fetch_enable_o, exp_fe);
      end
      tests_run++;
      if (state_o !== exp_st) begin
        tests_failed++;
        $display("FAIL long_low_state i=%0d got %0d exp %0d", i, state_o, exp_st);
      end
    end
  endtask

  task automatic test_mid_reset();
    async_pad = 3'b010;
    repeat (3) tick();
    tests_run++;
    if (fetch_enable_o !== 1'b1 || async_sync_o !== 3'b010) begin
      tests_failed++;
      $display("FAIL midrst_pre got fe=%b async=%b exp fe=1 async=010", fetch_enable_o,
               async_sync_o);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (core_rst_n_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_core_rst got %b exp 0", core_rst_n_o);
    end
    tests_run++;
    if (fetch_enable_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_fetch got %b exp 0", fetch_enable_o);
    end
    tests_run++;
    if (state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL midrst_state got %0d exp 0", state_o);
    end
    tests_run++;
    if (async_sync_o !== 3'b111) begin
      tests_failed++;
      $display("FAIL midrst_async got %b exp 111", async_sync_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= REL + 1; e++) begin
      logic [2:0] exp_as;
      tick();
      exp_as = (e >= S) ? 3'b010 : 3'b111;
      tests_run++;
      if (core_rst_n_o !== (e >= REL)) begin
        tests_failed++;
        $display("FAIL rerelease_core_rst edge %0d got %b exp %b", e, core_rst_n_o, e >= REL);
      end
      tests_run++;
      if (fetch_enable_o !== (e >= REL + 1)) begin
        tests_failed++;
        $display("FAIL rerelease_fetch edge %0d got %b exp %b", e, fetch_enable_o,
                 e >= REL + 1);
      end
      tests_run++;
      if (async_sync_o !== exp_as) begin
        tests_failed++;
        $display("FAIL rerelease_async edge %0d got %b exp %b", e, async_sync_o, exp_as);
      end
    end
  endtask

  task automatic test_async();
    logic [2:0] old_v;
    logic [2:0] new_v;
    old_v = async_pad;
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        // Repeat while the FSM sits in HOLD
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
      end
      for (int r = 0; r < 3; r++) begin
        new_v = 3'($urandom);
        if (new_v == old_v) new_v = ~old_v;
        async_pad = new_v;
        for (int i = 0; i <= S; i++) begin
          logic [2:0] exp_as;
          tick();
          exp_as = (i >= S - 1) ? new_v : old_v;
          tests_run++;
          if (async_sync_o !== exp_as) begin
            tests_failed++;
            $display("FAIL async_latency ph=%0d i=%0d got %b exp %b", phase, i, async_sync_o,
                     exp_as);
          end
        end
        old_v = new_v;
      end
      tests_run++;
      if (state_o !== (phase == 1 ? 2'd0 : 2'd2)) begin
        tests_failed++;
        $display("FAIL async_state ph=%0d got %0d", phase, state_o);
      end
    end
  endtask

  task automatic test_random();
    int rst_hold;
    rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] exp_st;
      exp_st = core_m ? (fe_m ? 2'd2 : 2'd1) : 2'd0;
      tests_run++;
      if (core_rst_n_o !== core_m) begin
        tests_failed++;
        $display("FAIL rand_core_rst cyc %0d got %b exp %b", c, core_rst_n_o, core_m);
      end
      tests_run++;
      if (fetch_enable_o !== fe_m) begin
        tests_failed++;
        $display("FAIL rand_fetch cyc %0d got %b exp %b", c, fetch_enable_o, fe_m);
      end
      tests_run++;
      if (state_o !== exp_st) begin
        tests_failed++;
        $display("FAIL rand_state cyc %0d got %0d exp %0d", c, state_o, exp_st);
      end
      tests_run++;
      if (async_sync_o !== as_hist[S-1]) begin
        tests_failed++;
        $display("FAIL rand_async cyc %0d got %b exp %b", c, async_sync_o, as_hist[S-1]);
      end
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (core_rst_n_o !== 1'b0 || fetch_enable_o !== 1'b0 || async_sync_o !== 3'b111) begin
          tests_failed++;
          $display("FAIL rand_async_reset cyc %0d got rst=%b fe=%b async=%b", c, core_rst_n_o,
                   fetch_enable_o, async_sync_o);
        end
        rst_hold = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 5) == 0) fetch_pad = ~fetch_pad;
      if ($urandom_range(0, 3) == 0) async_pad = 3'($urandom);
      tick();
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    fetch_pad    = 1'b0;
    async_pad    = 3'b111;
    model_reset();
    @(negedge clk);
    test_reset();
    test_fetch_high();
    test_debounce();
    test_mid_reset();
    test_async();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pad_in_conditioner.md
# pad_in_conditioner

Conditions every asynchronous input that arrives from the input pad cells before it reaches `pulpino_top`. Its jobs:
- Stretch and release the core reset synchronously.
- Synchronise `fetch_enable` and the UART modem/receive lines into the `clk` domain.
- Debounce `fetch_enable`.
- Gate fetch until the core is out of reset.

It is instantiated in `top_top`, between the `CPAD_S_74x50u_IN` core-side nets and the `pulpino_top` ports.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of every synchroniser (legal 2..4).
- `RST_HOLD_CYCLES`, 16: cycles core reset stays asserted after synchronised release (legal 1..255).
- `DEBOUNCE_CYCLES`, 8: consecutive stable cycles needed to change filtered fetch enable (legal 1..255).
- `N_ASYNC`, 3: number of generic async lines; bit 0 uart_rx, bit 1 uart_cts, bit 2 uart_dsr.
- `ASYNC_RST_VAL`, 3'b111: reset value of `async_sync_o`; UART lines idle high.

Ports:
- `clk` in 1: core clock from clock pad; the only clock.
- `rst_n` in 1: pad reset; asynchronous, active-low.
- `fetch_enable_pad_i` in 1: raw fetch enable from pad.
- `async_pad_i` in N_ASYNC: raw uart_rx/cts/dsr from pads.
- `core_rst_n_o` out 1: reset to `pulpino_top`; asynchronous assert, synchronous deassert.
- `fetch_enable_o` out 1: conditioned fetch enable to `pulpino_top`.
- `async_sync_o` out N_ASYNC: synchronised copies of `async_pad_i`.
- `state_o` out 2: FSM state; HOLD=0, IDLE=1, RUN=2.

## Operation
- All flops are reset directly by `rst_n` (async, active-low). Nothing is reset synchronously.
- Reset values:
  - `core_rst_n_o`=0, `fetch_enable_o`=0, `state_o`=HOLD.
  - `async_sync_o`=ASYNC_RST_VAL.
  - Synchroniser chains: ASYNC_RST_VAL bits for async lines, 0 for fetch and reset chains.
- Reset synchroniser:
  - SYNC_STAGES-deep chain shifting in 1.
  - Its last stage `rst_rel` enables the hold counter.
- Hold counter:
  - 8-bit; clears in reset.
  - Increments while `rst_rel`=1 in HOLD.
- FSM:
  - HOLD -> IDLE when the counter reaches RST_HOLD_CYCLES-1 and `rst_rel`=1. `core_rst_n_o` rises on the same edge (registered output).
  - IDLE -> RUN when filtered fetch enable `fe_f`=1.
  - RUN -> IDLE when `fe_f`=0.
  - No path back to HOLD except `rst_n` assertion.
- `fetch_enable_o` = registered (state==RUN next-state). It is 0 in HOLD and IDLE, 1 only in RUN.
- Debounce, per cycle:
  - If synced fetch `fe_s` equals `fe_f`: counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with `fe_s`≠`fe_f`: `fe_f` <= `fe_s` and the counter clears.
  - Runs in all states, including HOLD.
- `async_sync_o[i]` is the last stage of a SYNC_STAGES chain on `async_pad_i[i]`. There is no filtering on these lines.
- `rst_n` assertion mid-operation: all outputs return to reset values immediately (asynchronously, no clock needed). The full release sequence repeats on deassertion.

## Timing
- Edge numbering: first `clk` rising edge after `rst_n` rises = edge 1.
  - `rst_rel`=1 after edge SYNC_STAGES.
  - `core_rst_n_o`=1 after edge SYNC_STAGES+RST_HOLD_CYCLES; 18 with defaults.
- Fetch path: pad fetch changes stably before edge E, with `core_rst_n_o`=1 and the `DEBOUNCE_FETCH_EN` filter compiled in.
  - `fe_s` changes after edge E+SYNC_STAGES-1.
  - `fe_f` changes after edge E+SYNC_STAGES-1+DEBOUNCE_CYCLES.
  - `fetch_enable_o` changes one edge later: E+SYNC_STAGES+DEBOUNCE_CYCLES; 10 with defaults.
- A pulse on `fe_s` shorter than DEBOUNCE_CYCLES cycles produces no change on `fetch_enable_o`.
- If fetch is held high from power-up, `fetch_enable_o` rises on the edge after `core_rst_n_o` rises: IDLE is occupied for exactly 1 cycle, provided `fe_f` has already settled.
- Async lines: latency SYNC_STAGES edges.

## Configuration
- Macro: `DEBOUNCE_FETCH_EN`.
- Defined: debounce counter and `fe_f` are present, as described above.
- Undefined: no debounce counter; `fe_f` = `fe_s` combinationally. Fetch latency becomes SYNC_STAGES+1 edges, and every `fe_s` transition of any length propagates. FSM, reset path and async lines are unchanged.

## Test plan
- Power-up: hold `rst_n`=0 for 5 cycles, release, pad fetch=0 -> `core_rst_n_o` 0 through edge 17, 1 after edge 18; `state_o` 0 -> 1; `fetch_enable_o`=0.
- Fetch tied high from time 0, release reset -> `core_rst_n_o` rises after edge 18, `fetch_enable_o` after edge 19, `state_o`=2.
- Core running in RUN; fetch pulse low for 5 cycles -> `fetch_enable_o` stays 1. Then low for 12 cycles -> `fetch_enable_o` falls 10 edges after the fall, `state_o`=1.
- `rst_n` asserted mid-RUN between edges -> `core_rst_n_o`, `fetch_enable_o` go 0 and `async_sync_o` goes 3'b111 before the next edge. Re-release repeats the 18-edge sequence.
- `async_pad_i` 3'b111 -> 3'b010 before edge E -> `async_sync_o`=3'b010 after edge E+1, independent of FSM state.
- `DEBOUNCE_FETCH_EN` undefined: a 1-cycle fetch glitch in RUN -> `fetch_enable_o` low for exactly 1 cycle, 3 edges after the glitch.
